// File: rtl/mux_out_fifo.sv
// Show-ahead FIFO that buffers the 2:1 selector output for a slower consumer.
// Define MUX_OUT_FIFO_STATS_EN to build the saturating overflow drop counter.
module mux_out_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic [7:0]                 drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             wr_en, rd_en;

    // Flags come only from the registered count, so out_ready never reaches in_ready.
    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign count     = count_q;
    assign out_data  = empty ? '0 : mem_q[rd_ptr_q];

    assign wr_en = in_valid && !full;
    assign rd_en = out_ready && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately unreset; the empty gating on out_data hides stale entries.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= in_data;
    end

`ifdef MUX_OUT_FIFO_STATS_EN
    logic [7:0] drop_q, drop_d;

    always_comb begin
        drop_d = drop_q;
        if (in_valid && full && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) drop_q <= 8'h00;
        else     drop_q <= drop_d;
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = 8'h00;
`endif

endmodule
